arbiter_rr_7_requests: RTL and testbench
========================================

# arbiter_rr_7_requests

Round-robin arbiter that shares one datapath resource (bus driver, memory port or ALU) of the prototype processor between seven requesters. Each request input has a per-bit polarity mask, the same bubble convention as the gate library. The arbiter issues a registered one-hot grant and holds it until the owner releases it, drops its request, or exceeds a hold limit. A one-cycle turnaround gap always separates two grants.

## Interface
- `RequestInvertMask`, default 0, 7 bits: bit i set means `Request_(i+1)` is active-low.
- `MaxHold`, default 15, 8 bits: maximum number of consecutive cycles a grant may stay asserted. 0 means unlimited.
- `Clock` in 1: the single clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `Request_1` … `Request_7` in 1 each: raw request lines, before the mask is applied.
- `Release` in 1: the current owner is done; sampled only in GRANT.
- `Grant_1` … `Grant_7` out 1 each: registered, at most one high at a time.
- `Grant_Valid` out 1: registered; equals the OR of all `Grant_*`.
- `Grant_Index` out 3: registered; owner number 1..7, or 0 when nothing is granted.
- `Any_Request` out 1: combinational OR of the seven effective requests.
- `Timeout` out 1: registered one-cycle pulse when a grant is forcibly revoked.

## Operation
- Effective request: r[i] = `Request_(i+1)` XOR `RequestInvertMask`[i]. Every decision uses r, never the raw inputs.
- Priority pointer `last` (3 bits, 0..6) holds the index of the most recent winner. Search order is `last`+1, `last`+2, … mod 7; the first index with r=1 wins.
- Hold counter `hcnt` is 8 bits.
- FSM states: IDLE, GRANT, GAP.
- IDLE: all grants 0.
  - Any r=1: register the winner's grant, set `last` to the winner, set `hcnt` to 1, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: the owner keeps its grant.
  - `Release`=1 or r[owner]=0: clear the grant, go to GAP.
  - Otherwise, if `MaxHold`≠0 and `hcnt`=`MaxHold`: clear the grant, set `Timeout`=1 for the next cycle, go to GAP.
  - Otherwise: increment `hcnt` (saturating at 255), stay in GRANT.
- GAP: all grants 0 for exactly this cycle. Then arbitrate exactly as IDLE does: go to GRANT if any r=1, otherwise to IDLE.
  - The previous owner is searched last. It can win again only if no other r=1.
- Release or request-drop coincident with the hold limit counts as a normal release; `Timeout` stays 0.
- r[owner] toggling while other requests arrive does not preempt the owner. Only the three exit conditions above end a grant.

## Timing
- Reset values: state IDLE, `last`=6 (requester 1 has highest priority first), `hcnt`=0. All `Grant_*`=0, `Grant_Valid`=0, `Grant_Index`=0, `Timeout`=0.
- `Any_Request` is combinational and has no reset dependence.
- Grant latency: r sampled high at edge N in IDLE or GAP puts the grant high during cycle N+1.
- Release latency: `Release` high at edge N puts the grant low during cycle N+1. The earliest next grant is cycle N+2.
- Grant duration with `MaxHold`=M≠0: at most M cycles. `Timeout` is high in the first cycle after revocation (the GAP cycle).
- `Reset` asserted mid-grant: all outputs return to reset values in the cycle after the edge, and `last` is restored to 6.
- A request asserted and withdrawn between two edges is never seen; there is no latching of requests.

## Test plan
- Reset then idle. Hold `Reset`=1 for 2 cycles with all r=0 → all `Grant_*`=0, `Grant_Index`=0, `Any_Request`=0.
- Round-robin order.
  - Stimulus: r1, r3 and r7 held high; each owner pulses `Release` one cycle after its grant.
  - Required response: grant sequence 1, 3, 7, 1, …, with exactly one zero-grant cycle between grants.
- Polarity mask. With `RequestInvertMask`=7'b0000100 and all raw requests 0 → r3=1, `Any_Request`=1, `Grant_3` high one cycle later.
- Hold limit. `MaxHold`=4, r2 held high, `Release`=0 → `Grant_2` high for exactly 4 cycles, then `Timeout`=1 for 1 cycle with grants 0. `Grant_2` returns after that gap cycle if r2 is still high.
- Coincident release and limit. `MaxHold`=3 and `Release`=1 in the 3rd grant cycle → grant drops, `Timeout` stays 0.
- Reset mid-grant. Assert `Reset` while `Grant_5`=1 with r1 and r5 high → next cycle all grants 0. After `Reset` deasserts, the first grant goes to requester 1.

Source files
------------

// File: rtl/arbiter_rr_7_requests.sv
// Round-robin arbiter for seven requesters with per-bit request polarity,
// a registered one-hot grant, a hold limit and a one-cycle gap between grants.
module arbiter_rr_7_requests #(
  parameter logic [6:0] RequestInvertMask = '0,
  parameter logic [7:0] MaxHold           = 8'd15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Request_1,
  input  logic       Request_2,
  input  logic       Request_3,
  input  logic       Request_4,
  input  logic       Request_5,
  input  logic       Request_6,
  input  logic       Request_7,
  input  logic       Release,
  output logic       Grant_1,
  output logic       Grant_2,
  output logic       Grant_3,
  output logic       Grant_4,
  output logic       Grant_5,
  output logic       Grant_6,
  output logic       Grant_7,
  output logic       Grant_Valid,
  output logic [2:0] Grant_Index,
  output logic       Any_Request,
  output logic       Timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t      state;
  logic [2:0]  last;
  logic [7:0]  hcnt;
  logic [6:0]  grant;
  logic [2:0]  grant_index;
  logic        grant_valid;
  logic        timeout;

  logic [6:0]  r;
  logic [2:0]  cand;
  logic [2:0]  win_idx;
  logic        win_found;

  assign r = {Request_7, Request_6, Request_5, Request_4,
              Request_3, Request_2, Request_1} ^ RequestInvertMask;

  assign Any_Request = |r;

  // Scan from farthest to nearest so the nearest requester after last wins;
  // the previous owner (k = 7) is therefore considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 7; k > 0; k--) begin
      cand = 3'((32'(last) + k) % 7);
      if (r[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      last        <= 3'd6;
      hcnt        <= '0;
      grant       <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (win_found) begin
            state       <= GRANT;
            last        <= win_idx;
            hcnt        <= 8'd1;
            grant       <= 7'b1 << win_idx;
            grant_index <= win_idx + 3'd1;
            grant_valid <= 1'b1;
          end else begin
            state       <= IDLE;
            grant       <= '0;
            grant_index <= '0;
            grant_valid <= 1'b0;
          end
        end
        GRANT: begin
          // A voluntary release takes precedence over the hold limit.
          if (Release || !r[last]) begin
            state       <= GAP;
            grant       <= '0;
            grant_index <= '0;
            grant_valid <= 1'b0;
          end else if (MaxHold != 8'd0 && hcnt == MaxHold) begin
            state       <= GAP;
            grant       <= '0;
            grant_index <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
          end else if (hcnt != 8'hFF) begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_index <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Grant_1     = grant[0];
  assign Grant_2     = grant[1];
  assign Grant_3     = grant[2];
  assign Grant_4     = grant[3];
  assign Grant_5     = grant[4];
  assign Grant_6     = grant[5];
  assign Grant_7     = grant[6];
  assign Grant_Valid = grant_valid;
  assign Grant_Index = grant_index;
  assign Timeout     = timeout;

endmodule

// File: tb/tb_arbiter_rr_7_requests.sv
// Directed bench: main arbiter (mask 0, hold limit 4) plus a second instance
// (request 3 active-low, hold limit 3) for polarity and coincident release.
module tb_arbiter_rr_7_requests;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] req;
  logic       rel;

  logic [6:0] g_a, g_p;
  logic       valid_a, valid_p, any_a, any_p, to_a, to_p;
  logic [2:0] idx_a, idx_p;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arbiter_rr_7_requests #(.RequestInvertMask(7'b0000000), .MaxHold(8'd4)) dut_a (
    .Clock(clk), .Reset(rst),
    .Request_1(req[0]), .Request_2(req[1]), .Request_3(req[2]), .Request_4(req[3]),
    .Request_5(req[4]), .Request_6(req[5]), .Request_7(req[6]), .Release(rel),
    .Grant_1(g_a[0]), .Grant_2(g_a[1]), .Grant_3(g_a[2]), .Grant_4(g_a[3]),
    .Grant_5(g_a[4]), .Grant_6(g_a[5]), .Grant_7(g_a[6]),
    .Grant_Valid(valid_a), .Grant_Index(idx_a), .Any_Request(any_a), .Timeout(to_a)
  );

  arbiter_rr_7_requests #(.RequestInvertMask(7'b0000100), .MaxHold(8'd3)) dut_p (
    .Clock(clk), .Reset(rst),
    .Request_1(req[0]), .Request_2(req[1]), .Request_3(req[2]), .Request_4(req[3]),
    .Request_5(req[4]), .Request_6(req[5]), .Request_7(req[6]), .Release(rel),
    .Grant_1(g_p[0]), .Grant_2(g_p[1]), .Grant_3(g_p[2]), .Grant_4(g_p[3]),
    .Grant_5(g_p[4]), .Grant_6(g_p[5]), .Grant_7(g_p[6]),
    .Grant_Valid(valid_p), .Grant_Index(idx_p), .Any_Request(any_p), .Timeout(to_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [6:0] g, input logic [2:0] idx, input logic to);
    chk({tag, "_grant"}, 32'(g_a), 32'(g));
    chk({tag, "_index"}, 32'(idx_a), 32'(idx));
    chk({tag, "_valid"}, 32'(valid_a), 32'(|g));
    chk({tag, "_timeout"}, 32'(to_a), 32'(to));
  endtask

  int rr_seq [4] = '{1, 3, 7, 1};

  initial begin
    rst = 1'b1;
    req = '0;
    rel = 1'b0;

    // Reset then idle
    tick();
    tick();
    chk_a("reset", 7'b0, 3'd0, 1'b0);
    chk("reset_any", 32'(any_a), 32'd0);
    rst = 1'b0;
    tick();
    chk_a("idle", 7'b0, 3'd0, 1'b0);

    // Round-robin with requesters 1, 3, 7; one gap cycle between grants
    req = 7'b1000101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a($sformatf("rr%0d", i), 7'(7'b1 << (rr_seq[i] - 1)), 3'(rr_seq[i]), 1'b0);
      rel = 1'b1;
      tick();
      chk_a($sformatf("rr%0d_gap", i), 7'b0, 3'd0, 1'b0);
      rel = 1'b0;
    end
    req = '0;
    tick();
    chk_a("rr_idle", 7'b0, 3'd0, 1'b0);

    // Hold limit 4 on requester 2
    req = 7'b0000010;
    #1;
    chk("hold_any", 32'(any_a), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk_a($sformatf("hold_c%0d", c), 7'b0000010, 3'd2, 1'b0);
    end
    tick();
    chk_a("hold_revoke", 7'b0, 3'd0, 1'b1);
    tick();
    chk_a("hold_regrant", 7'b0000010, 3'd2, 1'b0);

    // Requester 2 drops; requester 5 wins before 1; reset mid-grant
    req = 7'b0010001;
    tick();
    chk_a("drop_gap", 7'b0, 3'd0, 1'b0);
    tick();
    chk_a("grant5", 7'b0010000, 3'd5, 1'b0);
    rst = 1'b1;
    tick();
    chk_a("mid_reset", 7'b0, 3'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk_a("post_reset", 7'b0000001, 3'd1, 1'b0);

    // Polarity mask: raw requests all 0 still request on line 3
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("pol_any", 32'(any_p), 32'd1);
    chk("pol_reset_grant", 32'(g_p), 32'd0);
    tick();
    chk("pol_grant", 32'(g_p), 32'b0000100);
    chk("pol_index", 32'(idx_p), 32'd3);

    // Release coincident with the third (limit) grant cycle: no timeout
    tick();
    chk("coin_c2", 32'(g_p), 32'b0000100);
    tick();
    chk("coin_c3", 32'(g_p), 32'b0000100);
    rel = 1'b1;
    tick();
    chk("coin_gap_grant", 32'(g_p), 32'd0);
    chk("coin_gap_valid", 32'(valid_p), 32'd0);
    chk("coin_timeout", 32'(to_p), 32'd0);
    rel = 1'b0;
    tick();
    chk("coin_regrant", 32'(g_p), 32'b0000100);
    chk("coin_regrant_timeout", 32'(to_p), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
